decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode stage between the IF/ID and ID/EX pipeline boundaries. It decodes the fetched instruction and resolves both source operands through a configurable number of prioritised forwarding ports. It detects load-use hazards against the entry it currently holds and inserts bubbles for them. It owns the ID/EX pipeline register, with valid/ready handshakes on both sides plus a flush input.

## Interface
Parameters:
- NUM_FWD, 3, number of forwarding sources; index 0 has the highest priority (youngest producer).
- NREG, 32, architectural register count; register 0 is hardwired zero.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_state  in  if_id  fetched instruction, PC and valid.
- in_ready  out  1  stage accepts in_state this cycle.
- fwd  in  reg_writer[NUM_FWD]  forwarding sources: write-enable, destination and data.
- regs_value  in  word_t[NREG]  architectural register file contents.
- flush  in  1  kill the held entry and drop the input this cycle.
- out_state  out  id_ex  registered decoded entry.
- out_valid  out  1  out_state is meaningful.
- out_ready  in  1  EX consumes out_state this cycle.
- stall_count  out  CNT_W  saturating count of load-use bubble cycles.

## Operation
- Decode is combinational on in_state.inst.
  - Instantiate parse_operation and arith_decoder unchanged.
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- Operand resolution, per rs:
  - If rs == 0, the value is 0.
  - Otherwise take the lowest index i with fwd[i].reg_write_enable && fwd[i].reg_dest_addr == rs, and use fwd[i].reg_write_data.
  - Otherwise use regs_value[rs].
- Load-use hazard: out_valid && out_state.op is a load && out_state.writer.reg_write_enable && out_state.writer.reg_dest_addr != 0 && dest equals a used rs of the incoming valid instruction.
- Stores and branches use both rs1 and rs2. I-type instructions use only rs1. LUI/AUIPC/JAL use no source registers.
- Handshakes:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Accept = in_state.valid && in_ready. On accept, load the register with the decoded entry and set out_valid=1.
  - Hazard && out_ready: set out_valid=0 (bubble), hold the input, and increment stall_count.
  - out_ready && no accept: set out_valid=0.
  - Otherwise hold the register unchanged.
- Flush has priority over everything: out_valid=0 next cycle and nothing is accepted.
- stall_count saturates at all-ones and never wraps.

## Timing
- Reset (reset=0, asynchronous): out_valid=0, out_state all zeros, stall_count=0, in_ready deasserted while in reset.
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready is held high.
- A load-use dependency costs exactly one bubble cycle. Next cycle the load has moved to MEM, and its data arrives via a fwd port.
- Backpressure (out_ready=0): out_state stays stable, in_ready=0, and no hazard bubble is counted.
- Flush and hazard in the same cycle: flush wins and no stall is counted.
- Forwarding is combinational from fwd to the register D input. There is no stale capture: operands sample fwd in the accept cycle.
- Reset deasserted mid-stream: the first cycle after release behaves as empty.

## Structure
- Keep if_id, id_ex and reg_writer in combined_wire/temp_storage.
- Add a load-class predicate on instruction_type to common.
- Add a rs-usage function (uses_rs1/uses_rs2) to common.
- Sub-module operand_forward, parametrised by NUM_FWD and NREG and instantiated twice. It maps (rs, fwd, regs_value) to a word_t operand.

## Test plan
- Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 with fwd[0]={1,x1,5} → second entry reg1_value=reg2_value=5, no bubble.
- fwd[0] and fwd[2] both target x3 (data 7 vs 9) → operand is 7. Target x0 with data 0xFF → operand 0.
- LD x4,0(x5) held, then ADD x6,x4,x0 presented → one cycle out_valid=0, stall_count=1, ADD accepted the following cycle.
- LD x4 followed by LUI x4,1 → no hazard and no bubble, because LUI has no source registers.
- out_ready=0 for 3 cycles with a valid held entry → out_state unchanged, in_ready=0, stall_count unchanged.
- Flush with a hazard pending → out_valid=0 next cycle, stall_count unchanged. An asynchronous reset mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared types and decode helpers for the ID stage: pipeline boundary structs,
// opcode classification, ALU selection, immediate extraction and rs-usage predicates.
package decode_stage_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    OP_INVALID = 4'd0,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_IMM,
    OP_REG,
    OP_IMM32,
    OP_REG32
  } instruction_type;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef struct packed {
    logic      reg_write_enable;
    reg_addr_t reg_dest_addr;
    word_t     reg_write_data;
  } reg_writer;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] inst;
  } if_id;

  typedef struct packed {
    word_t           pc;
    logic [31:0]     inst;
    instruction_type op;
    alu_op_t         alu;
    word_t           imm;
    reg_addr_t       rs1;
    reg_addr_t       rs2;
    word_t           reg1_value;
    word_t           reg2_value;
    reg_writer       writer;
  } id_ex;

  function automatic instruction_type parse_operation(input logic [6:0] opcode);
    case (opcode)
      7'b0110111: return OP_LUI;
      7'b0010111: return OP_AUIPC;
      7'b1101111: return OP_JAL;
      7'b1100111: return OP_JALR;
      7'b1100011: return OP_BRANCH;
      7'b0000011: return OP_LOAD;
      7'b0100011: return OP_STORE;
      7'b0010011: return OP_IMM;
      7'b0110011: return OP_REG;
      7'b0011011: return OP_IMM32;
      7'b0111011: return OP_REG32;
      default:    return OP_INVALID;
    endcase
  endfunction

  function automatic alu_op_t arith_decoder(input logic [2:0] funct3, input logic funct7_5,
                                            input instruction_type op);
    alu_op_t alu;
    alu = ALU_ADD;
    if (op inside {OP_IMM, OP_REG, OP_IMM32, OP_REG32}) begin
      case (funct3)
        3'b000: alu = (funct7_5 && (op == OP_REG || op == OP_REG32)) ? ALU_SUB : ALU_ADD;
        3'b001: alu = ALU_SLL;
        3'b010: alu = ALU_SLT;
        3'b011: alu = ALU_SLTU;
        3'b100: alu = ALU_XOR;
        3'b101: alu = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu = ALU_OR;
        default: alu = ALU_AND;
      endcase
    end
    return alu;
  endfunction

  // Opcode bits are not needed here, the classified op selects the format.
  function automatic word_t imm_decode(input logic [31:7] ib, input instruction_type op);
    case (op)
      OP_STORE:         return {{52{ib[31]}}, ib[31:25], ib[11:7]};
      OP_BRANCH:        return {{51{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      OP_LUI, OP_AUIPC: return {{32{ib[31]}}, ib[31:12], 12'b0};
      OP_JAL:           return {{43{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default:          return {{52{ib[31]}}, ib[31:20]};
    endcase
  endfunction

  function automatic logic is_load(input instruction_type op);
    return op == OP_LOAD;
  endfunction

  function automatic logic uses_rs1(input instruction_type op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_IMM32, OP_REG32};
  endfunction

  function automatic logic uses_rs2(input instruction_type op);
    return op inside {OP_BRANCH, OP_STORE, OP_REG, OP_REG32};
  endfunction

  function automatic logic writes_rd(input instruction_type op);
    return !(op inside {OP_BRANCH, OP_STORE, OP_INVALID});
  endfunction

endpackage

// File: rtl/decode_stage_operand_forward.sv
// Resolves one source operand: x0 -> 0, else lowest-index matching forward port, else register file.
// Purely combinational, no backpressure.
module operand_forward
  import decode_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int NREG    = 32
) (
  input  reg_addr_t rs_i,
  input  reg_writer fwd_i [NUM_FWD],
  input  word_t     regs_value_i [NREG],
  output word_t     operand_o
);

  always_comb begin
    operand_o = '0;
    if (rs_i != '0) begin
      if (int'(rs_i) < NREG) operand_o = regs_value_i[rs_i];
      // Walk from oldest to youngest so the lowest index ends up winning.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_i[i].reg_write_enable && fwd_i[i].reg_dest_addr == rs_i)
          operand_o = fwd_i[i].reg_write_data;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with operand forwarding and load-use bubbling; owns the ID/EX register.
// One-cycle latency; in_ready drops on out_ready=0, load-use hazard, flush or reset.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int NREG    = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  if_id             in_state,
  output logic             in_ready,
  input  reg_writer        fwd [NUM_FWD],
  input  word_t            regs_value [NREG],
  input  logic             flush,
  output id_ex             out_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_count
);

  id_ex             out_state_q, out_state_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  instruction_type dec_op;
  reg_addr_t       dec_rs1, dec_rs2, dec_rd;
  word_t           rs1_val, rs2_val;
  id_ex            dec_entry;
  reg_addr_t       load_dest;
  logic            hazard, accept;

  assign dec_op  = parse_operation(in_state.inst[6:0]);
  assign dec_rs1 = in_state.inst[19:15];
  assign dec_rs2 = in_state.inst[24:20];
  assign dec_rd  = in_state.inst[11:7];

  operand_forward #(.NUM_FWD(NUM_FWD), .NREG(NREG)) u_fwd_rs1 (
    .rs_i         (dec_rs1),
    .fwd_i        (fwd),
    .regs_value_i (regs_value),
    .operand_o    (rs1_val)
  );

  operand_forward #(.NUM_FWD(NUM_FWD), .NREG(NREG)) u_fwd_rs2 (
    .rs_i         (dec_rs2),
    .fwd_i        (fwd),
    .regs_value_i (regs_value),
    .operand_o    (rs2_val)
  );

  always_comb begin
    dec_entry                         = '0;
    dec_entry.pc                      = in_state.pc;
    dec_entry.inst                    = in_state.inst;
    dec_entry.op                      = dec_op;
    dec_entry.alu                     = arith_decoder(in_state.inst[14:12], in_state.inst[30], dec_op);
    dec_entry.imm                     = imm_decode(in_state.inst[31:7], dec_op);
    dec_entry.rs1                     = dec_rs1;
    dec_entry.rs2                     = dec_rs2;
    dec_entry.reg1_value              = rs1_val;
    dec_entry.reg2_value              = rs2_val;
    dec_entry.writer.reg_write_enable = writes_rd(dec_op);
    dec_entry.writer.reg_dest_addr    = dec_rd;
  end

  // A load still sitting in ID/EX cannot forward yet; its data only appears once it reaches MEM.
  assign load_dest = out_state_q.writer.reg_dest_addr;
  assign hazard = in_state.valid && out_valid_q && is_load(out_state_q.op)
                  && out_state_q.writer.reg_write_enable && (load_dest != '0)
                  && ((uses_rs1(dec_op) && dec_rs1 == load_dest)
                   || (uses_rs2(dec_op) && dec_rs2 == load_dest));

  assign in_ready = reset && (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_state.valid && in_ready;

  always_comb begin
    out_state_d   = out_state_q;
    out_valid_d   = out_valid_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_state_d = dec_entry;
      out_valid_d = 1'b1;
    end else if (hazard && out_ready) begin
      out_valid_d = 1'b0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state_q   <= '0;
      out_valid_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      out_state_q   <= out_state_d;
      out_valid_q   <= out_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_state   = out_state_q;
  assign out_valid   = out_valid_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of expected ID/EX entries plus hazard/flush/reset checks.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int NUM_FWD = 3;
  localparam int NREG    = 32;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             reset;
  if_id             in_state;
  logic             in_ready;
  reg_writer        fwd [NUM_FWD];
  word_t            regs_value [NREG];
  logic             flush;
  id_ex             out_state;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] stall_count;

  typedef struct {
    word_t           pc;
    instruction_type op;
    reg_addr_t       rd;
    logic            we;
    word_t           v1;
    word_t           v2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  decode_stage #(.NUM_FWD(NUM_FWD), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_state    (in_state),
    .in_ready    (in_ready),
    .fwd         (fwd),
    .regs_value  (regs_value),
    .flush       (flush),
    .out_state   (out_state),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .stall_count (stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] addi(input reg_addr_t rd, input reg_addr_t rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] ld(input reg_addr_t rd, input reg_addr_t rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] add(input reg_addr_t rd, input reg_addr_t rs1, input reg_addr_t rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lui(input reg_addr_t rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic drive(input logic [31:0] inst, input word_t pc);
    in_state.valid = 1'b1;
    in_state.inst  = inst;
    in_state.pc    = pc;
  endtask

  task automatic clr_fwd();
    for (int i = 0; i < NUM_FWD; i++) fwd[i] = '0;
  endtask

  task automatic set_fwd(input int idx, input logic en, input reg_addr_t dst, input word_t data);
    fwd[idx].reg_write_enable = en;
    fwd[idx].reg_dest_addr    = dst;
    fwd[idx].reg_write_data   = data;
  endtask

  // Called just after a negedge: the presented instruction must be taken at the next posedge.
  task automatic accept_now(input word_t pc, input instruction_type op, input reg_addr_t rd,
                            input logic we, input word_t v1, input word_t v2);
    exp_t e;
    chk("accept_rdy", 64'(in_ready), 64'd1);
    e.pc = pc; e.op = op; e.rd = rd; e.we = we; e.v1 = v1; e.v2 = v2;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step(input word_t pc, input instruction_type op, input reg_addr_t rd,
                      input logic we, input word_t v1, input word_t v2);
    @(negedge clk);
    accept_now(pc, op, rd, we, v1, v2);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !flush) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_pc", out_state.pc, mon_e.pc);
        chk("out_op", 64'(out_state.op), 64'(mon_e.op));
        chk("out_rd", 64'(out_state.writer.reg_dest_addr), 64'(mon_e.rd));
        chk("out_we", 64'(out_state.writer.reg_write_enable), 64'(mon_e.we));
        chk("out_reg1", out_state.reg1_value, mon_e.v1);
        chk("out_reg2", out_state.reg2_value, mon_e.v2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) regs_value[i] = (i == 0) ? 64'd123 : 64'(i * 100);
    clr_fwd();
    drive(addi(5'd1, 5'd0, 12'd5), 64'h100);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_state_nonzero", 64'(out_state != '0), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // ADDI x1,x0,5 then ADD x2,x1,x1 with x1 forwarded
    @(negedge clk);
    reset = 1'b1;
    #1;
    accept_now(64'h100, OP_IMM, 5'd1, 1'b1, 64'd0, 64'd500);
    set_fwd(0, 1'b1, 5'd1, 64'd5);
    drive(add(5'd2, 5'd1, 5'd1), 64'h104);
    step(64'h104, OP_REG, 5'd2, 1'b1, 64'd5, 64'd5);

    // Priority: fwd[0] beats fwd[2]; disabled port ignored; x0 ignores reg file
    clr_fwd();
    set_fwd(0, 1'b1, 5'd3, 64'd7);
    set_fwd(1, 1'b0, 5'd3, 64'd8);
    set_fwd(2, 1'b1, 5'd3, 64'd9);
    drive(add(5'd7, 5'd3, 5'd0), 64'h108);
    step(64'h108, OP_REG, 5'd7, 1'b1, 64'd7, 64'd0);

    // Forward targeting x0 must not leak
    clr_fwd();
    set_fwd(0, 1'b1, 5'd0, 64'hFF);
    set_fwd(2, 1'b1, 5'd5, 64'h55);
    drive(add(5'd8, 5'd0, 5'd5), 64'h10C);
    step(64'h10C, OP_REG, 5'd8, 1'b1, 64'd0, 64'h55);

    // Load-use: LD x4,0(x5) then ADD x6,x4,x0 costs exactly one bubble
    clr_fwd();
    drive(ld(5'd4, 5'd5, 12'd0), 64'h110);
    step(64'h110, OP_LOAD, 5'd4, 1'b1, 64'd500, 64'd0);
    drive(add(5'd6, 5'd4, 5'd0), 64'h114);
    @(negedge clk);
    chk("hazard_in_ready", 64'(in_ready), 64'd0);
    chk("hazard_stall_before", 64'(stall_count), 64'd0);
    @(posedge clk); #1;
    set_fwd(0, 1'b1, 5'd4, 64'h444);
    @(negedge clk);
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_stall", 64'(stall_count), 64'd1);
    accept_now(64'h114, OP_REG, 5'd6, 1'b1, 64'h444, 64'd0);

    // LD x4 then LUI x4: no source registers, no bubble
    clr_fwd();
    drive(ld(5'd4, 5'd5, 12'd0), 64'h118);
    step(64'h118, OP_LOAD, 5'd4, 1'b1, 64'd500, 64'd0);
    drive(lui(5'd4, 20'd1), 64'h11C);
    @(negedge clk);
    chk("lui_stall", 64'(stall_count), 64'd1);
    accept_now(64'h11C, OP_LUI, 5'd4, 1'b1, 64'd0, 64'd0);

    // Backpressure for 3 cycles: entry stable, no input accepted, no stall counted
    drive(addi(5'd9, 5'd0, 12'd3), 64'h120);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc", out_state.pc, 64'h11C);
      chk("bp_op", 64'(out_state.op), 64'(OP_LUI));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stall", 64'(stall_count), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    step(64'h120, OP_IMM, 5'd9, 1'b1, 64'd0, 64'd300);

    // Flush while a load-use hazard is pending: flush wins, no stall counted
    drive(ld(5'd4, 5'd5, 12'd0), 64'h124);
    @(negedge clk);
    chk("ld_pre_flush_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(add(5'd6, 5'd4, 5'd0), 64'h128);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_stall", 64'(stall_count), 64'd1);
    accept_now(64'h128, OP_REG, 5'd6, 1'b1, 64'd400, 64'd0);

    // Asynchronous reset mid-stream clears outputs immediately
    drive(addi(5'd10, 5'd0, 12'd1), 64'h12C);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_stall", 64'(stall_count), 64'd0);
    chk("arst_state_nonzero", 64'(out_state != '0), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    accept_now(64'h12C, OP_IMM, 5'd10, 1'b1, 64'd0, 64'd100);

    in_state.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_stall", 64'(stall_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
